sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 76 +++++++
 tb/tb_sprite_rom_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin burst arbiter sharing one async-read sprite ROM, with registered pixel output.
module sprite_rom_arbiter #(
  parameter int ADDRESS = 10,
  parameter int COLOR_BITS = 24,
  parameter int N_REQ = 4,
  parameter int BURST = 32,
  parameter logic [COLOR_BITS-1:0] KEY = 24'hFF00FF,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1,
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDRESS-1:0] req_addr,
  output logic [N_REQ-1:0]         gnt,
  output logic [ADDRESS-1:0]       rom_addr,
  input  logic [COLOR_BITS-1:0]    rom_dout,
  output logic                     pix_valid,
  output logic [COLOR_BITS-1:0]    pix_data,
  output logic [IW-1:0]            pix_id,
  output logic                     pix_opaque,
  output logic                     pix_last,
  output logic                     busy
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] ptr, own, win;
  logic [CW-1:0] cnt;
  logic [ADDRESS-1:0] base;
  logic found;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && req[IW'((int'(ptr) + i) % N_REQ)]) begin
        found = 1'b1;
        win = IW'((int'(ptr) + i) % N_REQ);
      end
  end
  // gnt is combinational, so it is gated by rst to read 0 during reset
  assign gnt = (state == S_IDLE && found && !rst) ? N_REQ'(1) << win : '0;
  assign busy = state == S_BURST;
  assign rom_addr = busy ? base + ADDRESS'(cnt) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      ptr <= '0;
      own <= '0;
      cnt <= '0;
      base <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_id <= '0;
      pix_opaque <= 1'b0;
      pix_last <= 1'b0;
    end else begin
      pix_valid <= busy;
      pix_data <= busy ? rom_dout : '0;
      pix_id <= busy ? own : '0;
      pix_last <= busy && cnt == CW'(BURST - 1);
      pix_opaque <= busy && rom_dout != KEY;
      if (state == S_IDLE) begin
        if (found) begin
          state <= S_BURST;
          base <= req_addr[win*ADDRESS +: ADDRESS];
          own <= win;
          cnt <= '0;
          ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BURST - 1)) state <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed table of arbitration bursts plus hand sequences for wrap, key, drop and reset.
module tb_sprite_rom_arbiter;
  localparam logic [23:0] KEY = 24'hFF00FF;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0;
  logic [39:0] req_addr = {10'h300, 10'h040, 10'h200, 10'h100};
  logic [3:0] gnt;
  logic [9:0] rom_addr, key_addr = '0;
  logic [23:0] rom_dout, pix_data;
  logic pix_valid, pix_opaque, pix_last, busy;
  logic [1:0] pix_id;
  int mode = 0, tests = 0, fails = 0, waited;
  typedef struct { logic [3:0] req; int w; logic [9:0] b; } vec_t;
  vec_t tbl[9];

  sprite_rom_arbiter dut (.clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_id(pix_id), .pix_opaque(pix_opaque), .pix_last(pix_last), .busy(busy));

  always #5 clk = ~clk;
  always_comb rom_dout = mode == 0 ? {14'b0, rom_addr} : (rom_addr == key_addr ? KEY : 24'h123456);

  function automatic logic [23:0] exp_pix(input logic [9:0] a);
    return mode == 0 ? {14'b0, a} : (a == key_addr ? KEY : 24'h123456);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pix(input logic [9:0] a, input int w, input logic l);
    logic [23:0] e;
    e = exp_pix(a);
    chk("pix_valid", pix_valid, 1);
    chk("pix_data", pix_data, e);
    chk("pix_id", pix_id, w);
    chk("pix_last", pix_last, l);
    chk("pix_opaque", pix_opaque, e != KEY);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_gnt"}, gnt, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_rom_addr"}, rom_addr, 0);
    chk({name, "_pix_valid"}, pix_valid, 0);
    chk({name, "_pix_data"}, pix_data, 0);
    chk({name, "_pix_id"}, pix_id, 0);
    chk({name, "_pix_last"}, pix_last, 0);
    chk({name, "_pix_opaque"}, pix_opaque, 0);
  endtask

  // waits for a grant, then follows the burst up to the cycle after its last pixel
  task automatic burst(input int w, input logic [9:0] b, input int drop_at, input logic [3:0] req_after, output int n);
    logic [9:0] a;
    n = 0;
    #1;
    while (!(|gnt) && n < 64) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", gnt, 4'b0001 << w);
    if (n >= 64) return;
    chk("grant_busy", busy, 0);
    chk("grant_rom_addr", rom_addr, 0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk); #1;
      if (k == drop_at) req = req_after;
      a = b + 10'(k);
      chk("rom_addr", rom_addr, a);
      chk("busy", busy, 1);
      chk("no_gnt_in_burst", gnt, 0);
      if (k > 0) chk_pix(a - 10'd1, w, 1'b0);
    end
    @(negedge clk); #1;
    a = b + 10'd31;
    chk_pix(a, w, 1'b1);
    chk("bubble_busy", busy, 0);
    chk("bubble_rom_addr", rom_addr, 0);
  endtask

  initial begin
    tbl[0] = '{4'b0100, 2, 10'h040};
    tbl[1] = '{4'b1111, 3, 10'h300};
    tbl[2] = '{4'b1111, 0, 10'h100};
    tbl[3] = '{4'b1111, 1, 10'h200};
    tbl[4] = '{4'b1111, 2, 10'h040};
    tbl[5] = '{4'b1111, 3, 10'h300};
    tbl[6] = '{4'b1111, 0, 10'h100};
    tbl[7] = '{4'b0010, 1, 10'h200};
    tbl[8] = '{4'b0011, 0, 10'h100};
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 9; v++) begin
      req = tbl[v].req;
      burst(tbl[v].w, tbl[v].b, -1, 4'b0, waited);
      chk("no_extra_idle", waited, 0);
    end
    req = 4'b0010;
    burst(1, 10'h200, 10, 4'b0000, waited);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk_quiet("dropped_idle");
    end
    req_addr[29:20] = 10'h3F0;
    req = 4'b0100;
    burst(2, 10'h3F0, -1, 4'b0, waited);
    mode = 1;
    key_addr = 10'h105;
    req = 4'b0001;
    burst(0, 10'h100, -1, 4'b0, waited);
    mode = 0;
    req = 4'b1000;
    waited = 0;
    #1;
    while (!(|gnt) && waited < 64) begin
      @(negedge clk); #1; waited++;
    end
    chk("rst_test_grant", gnt, 4'b1000);
    repeat (11) @(negedge clk);
    #1;
    chk("beat10_addr", rom_addr, 10'h30A);
    chk("beat10_valid", pix_valid, 1);
    rst = 1'b1;
    #1;
    chk_quiet("mid_rst");
    @(negedge clk); #1;
    chk_quiet("mid_rst_held");
    req = 4'b1001;
    rst = 1'b0;
    burst(0, 10'h100, -1, 4'b0, waited);
    chk("post_rst_no_wait", waited, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
